seq_alu: RTL and testbench

- Parametrised, multi-cycle successor to the team's 4-bit combinational ALU.
- Width is set by WIDTH. Adds SUB, SLT, SLL and an iterative shift-add multiply.
- Produces zero and overflow flags and registers every result.
- Sits between operand fetch and writeback; uses a valid/ready handshake on both input and output so the datapath can stall on multi-cycle ops.

---
 rtl/seq_alu_if.sv | 26 ++
 rtl/seq_alu.sv | 146 ++++++++++++++
 tb/tb_seq_alu.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle for seq_alu: valid/ready on the operand side and on the result side.
// master = operand fetch / writeback side, slave = the ALU.
interface seq_alu_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] inA;
   logic [WIDTH-1:0] inB;
   logic [2:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] ans;
   logic             zero;
   logic             ovf;

   modport master (
      output in_valid, inA, inB, op, out_ready,
      input  in_ready, out_valid, ans, zero, ovf
   );

   modport slave (
      input  in_valid, inA, inB, op, out_ready,
      output in_ready, out_valid, ans, zero, ovf
   );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU with registered result/flags and valid/ready handshakes on both sides.
// Define SEQ_ALU_MUL_EN to build the iterative shift-add multiplier for op 111; otherwise op 111 returns 0.
module seq_alu #(
   parameter int WIDTH = 32
) (
   input logic      clk,
   input logic      reset,
   seq_alu_if.slave bus
);
   localparam int SHW = $clog2(WIDTH);

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_XOR = 3'b010;
   localparam logic [2:0] OP_ADD = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b100;
   localparam logic [2:0] OP_SLT = 3'b101;
   localparam logic [2:0] OP_SLL = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DONE = 2'd1
`ifdef SEQ_ALU_MUL_EN
      ,S_MUL = 2'd2
`endif
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] ans_q;
   logic             zero_q;
   logic             ovf_q;
   logic             out_valid_q;
   logic             in_ready_q;

   logic [WIDTH-1:0] res_d;
   logic             zero_d;
   logic             ovf_d;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;

   always_comb begin
      res_d = '0;
      ovf_d = 1'b0;
      sum   = bus.inA + bus.inB;
      diff  = bus.inA - bus.inB;
      case (bus.op)
         OP_AND: res_d = bus.inA & bus.inB;
         OP_OR:  res_d = bus.inA | bus.inB;
         OP_XOR: res_d = bus.inA ^ bus.inB;
         OP_ADD: begin
            res_d = sum;
            ovf_d = (bus.inA[WIDTH-1] == bus.inB[WIDTH-1]) && (sum[WIDTH-1] != bus.inA[WIDTH-1]);
         end
         OP_SUB: begin
            res_d = diff;
            ovf_d = (bus.inA[WIDTH-1] != bus.inB[WIDTH-1]) && (diff[WIDTH-1] != bus.inA[WIDTH-1]);
         end
         OP_SLT: res_d = {{(WIDTH-1){1'b0}}, ($signed(bus.inA) < $signed(bus.inB))};
         OP_SLL: res_d = bus.inA << bus.inB[SHW-1:0];
         default: res_d = '0;   // OP_MUL without the multiplier build
      endcase
      zero_d = (res_d == '0);
   end

`ifdef SEQ_ALU_MUL_EN
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [2*WIDTH-1:0] prod_q;
   logic [2*WIDTH-1:0] prod_d;
   logic [SHW-1:0]     cnt_q;

   // One partial product per cycle, LSB of B first.
   always_comb begin
      prod_d = prod_q + (b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0);
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         ans_q       <= '0;
         zero_q      <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
`ifdef SEQ_ALU_MUL_EN
         a_q         <= '0;
         b_q         <= '0;
         prod_q      <= '0;
         cnt_q       <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.in_valid) begin
                  in_ready_q <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
                  if (bus.op == OP_MUL) begin
                     a_q     <= bus.inA;
                     b_q     <= bus.inB;
                     prod_q  <= '0;
                     cnt_q   <= '0;
                     state_q <= S_MUL;
                  end else
`endif
                  begin
                     ans_q       <= res_d;
                     zero_q      <= zero_d;
                     ovf_q       <= ovf_d;
                     out_valid_q <= 1'b1;
                     state_q     <= S_DONE;
                  end
               end
            end
`ifdef SEQ_ALU_MUL_EN
            S_MUL: begin
               prod_q <= prod_d;
               cnt_q  <= cnt_q + 1'b1;
               if (cnt_q == SHW'(WIDTH-1)) begin
                  ans_q       <= prod_d[WIDTH-1:0];
                  zero_q      <= (prod_d[WIDTH-1:0] == '0);
                  ovf_q       <= |prod_d[2*WIDTH-1:WIDTH];
                  out_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end
            end
`endif
            S_DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.ans       = ans_q;
   assign bus.zero      = zero_q;
   assign bus.ovf       = ovf_q;
   assign bus.out_valid = out_valid_q;
   assign bus.in_ready  = in_ready_q;
endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=8; follows SEQ_ALU_MUL_EN for the op 111 expectations.
module tb_seq_alu;
   localparam int W = 8;

   logic clk;
   logic reset;
   int   n_total;
   int   n_pass;
   int   n_fail;

   seq_alu_if #(.WIDTH(W)) bus ();

   seq_alu #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one op for one edge; the bench samples right after the accepting edge.
   task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      bus.op       = o;
      bus.inA      = a;
      bus.inB      = b;
      bus.in_valid = 1'b1;
      check("in_ready_before_issue", 32'(bus.in_ready), 32'd1);
      step();
      bus.in_valid = 1'b0;
   endtask

   task automatic expect_result(input string tag, input logic [W-1:0] a, input logic z, input logic v);
      check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_ans"}, 32'(bus.ans), 32'(a));
      check({tag, "_zero"}, 32'(bus.zero), 32'(z));
      check({tag, "_ovf"}, 32'(bus.ovf), 32'(v));
   endtask

   task automatic drain();
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      check("drain_in_ready", 32'(bus.in_ready), 32'd1);
      check("drain_out_valid", 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      int n;
      logic saw_ready;
      n_total = 0;
      n_pass  = 0;
      n_fail  = 0;
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.op        = 3'b000;
      bus.inA       = '0;
      bus.inB       = '0;

      #2;
      check("rst_ans", 32'(bus.ans), 32'h0);
      check("rst_zero", 32'(bus.zero), 32'd0);
      check("rst_ovf", 32'(bus.ovf), 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      step();
      reset = 1'b0;
      step();

      issue(3'b011, 8'h7F, 8'h01);
      expect_result("add_7f_01", 8'h80, 1'b0, 1'b1);
      check("add_in_ready_low", 32'(bus.in_ready), 32'd0);
      drain();

      issue(3'b100, 8'h05, 8'h05);
      expect_result("sub_05_05", 8'h00, 1'b1, 1'b0);
      drain();

      issue(3'b100, 8'h80, 8'h01);
      expect_result("sub_80_01", 8'h7F, 1'b0, 1'b1);
      drain();

      issue(3'b101, 8'h80, 8'h01);
      expect_result("slt_80_01", 8'h01, 1'b0, 1'b0);
      drain();

      issue(3'b101, 8'h01, 8'h80);
      expect_result("slt_01_80", 8'h00, 1'b1, 1'b0);
      drain();

      issue(3'b110, 8'h01, 8'h0B);
      expect_result("sll_01_0b", 8'h08, 1'b0, 1'b0);
      drain();

      issue(3'b000, 8'hF0, 8'h3C);
      expect_result("and", 8'h30, 1'b0, 1'b0);
      drain();

      issue(3'b001, 8'hF0, 8'h0F);
      expect_result("or", 8'hFF, 1'b0, 1'b0);
      drain();

      issue(3'b010, 8'hFF, 8'h0F);
      expect_result("xor", 8'hF0, 1'b0, 1'b0);
      drain();

      issue(3'b011, 8'hFF, 8'h01);
      expect_result("add_ff_01", 8'h00, 1'b1, 1'b0);
      drain();

      // Backpressure: result must hold while new operands wave around on the input side.
      issue(3'b011, 8'h02, 8'h03);
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = ~bus.in_valid;
         bus.inA      = 8'($urandom);
         bus.inB      = 8'($urandom);
         bus.op       = 3'($urandom);
         step();
         expect_result("bp_hold", 8'h05, 1'b0, 1'b0);
         check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid = 1'b0;
      drain();

`ifdef SEQ_ALU_MUL_EN
      issue(3'b111, 8'h10, 8'h11);
      bus.inA = 8'hFF;
      bus.inB = 8'hFF;
      n = 0;
      saw_ready = 1'b0;
      while (!bus.out_valid && n < 40) begin
         if (bus.in_ready) saw_ready = 1'b1;
         step();
         n++;
      end
      check("mul_latency", 32'(n), 32'd8);
      check("mul_in_ready_low", 32'(saw_ready), 32'd0);
      expect_result("mul_10_11", 8'h10, 1'b0, 1'b1);
      drain();

      issue(3'b111, 8'h03, 8'h05);
      n = 0;
      while (!bus.out_valid && n < 40) begin
         step();
         n++;
      end
      check("mul2_latency", 32'(n), 32'd8);
      expect_result("mul_03_05", 8'h0F, 1'b0, 1'b0);
      drain();

      // Reset between edges during the fourth multiply cycle.
      issue(3'b111, 8'h07, 8'h09);
      step();
      step();
      step();
      #2;
      reset = 1'b1;
      #1;
`else
      issue(3'b111, 8'h10, 8'h11);
      expect_result("mul_disabled", 8'h00, 1'b1, 1'b0);
      drain();

      // Reset between edges while a result is pending.
      issue(3'b011, 8'h11, 8'h22);
      #2;
      reset = 1'b1;
      #1;
`endif
      check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("async_rst_ans", 32'(bus.ans), 32'h0);
      #2;
      reset = 1'b0;
      step();

      issue(3'b011, 8'h02, 8'h03);
      expect_result("post_rst_add", 8'h05, 1'b0, 1'b0);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
